audio_dac_tx: RTL and testbench
===============================

Name: audio_dac_tx

Overview:
- I2S-style serial transmitter toward the audio CODEC DAC. It is the transmit counterpart of the ADC capture path.
- Accepts stereo sample frames over a valid/ready handshake and buffers one frame.
- Shifts left/right words out MSB-first on AUD_DACDAT, framed by the CODEC-driven AUD_DACLRCK and clocked by AUD_BCLK.
- Sits between the playback/sample-rate logic and the WM8731 DAC pins.

Parameters:
BITLEN, 16, bits per channel word; legal range 8..32.

Ports:
AUD_BCLK  input  1  bit clock from the CODEC; sole clock, rising-edge.
i_rst_n  input  1  asynchronous active-low reset.
i_data_l  input  BITLEN  left sample, two's complement.
i_data_r  input  BITLEN  right sample, two's complement.
i_valid  input  1  frame on i_data_l/i_data_r is valid.
o_ready  output  1  holding register empty; a frame is accepted when i_valid && o_ready at a rising AUD_BCLK.
AUD_DACLRCK  input  1  channel clock from the CODEC; low = left, high = right.
AUD_DACDAT  output  1  serial data to the DAC, registered.
o_underrun  output  1  one-cycle pulse when a left channel starts with no buffered frame.

Behaviour:
- Clocking and reset:
  - Single clock AUD_BCLK; reset is asynchronous and active-low (i_rst_n).
  - All state is reset asynchronously.
- Reset values:
  - AUD_DACDAT=0, o_underrun=0, o_ready=1 (holding register empty).
  - Shift register = 0, bit counter = 0, previous-LRCK register = 0, state = S_IDLE.
- Edge detection: r_lrck_q registers AUD_DACLRCK every cycle.
  - Falling edge = r_lrck_q & ~AUD_DACLRCK.
  - Rising edge = ~r_lrck_q & AUD_DACLRCK.
- States: S_IDLE, S_LEFT, S_RWAIT, S_RIGHT, S_LWAIT.
  - S_IDLE: rising edges are ignored. A falling edge triggers a left start and moves to S_LEFT, so the first frame after reset always begins with left.
  - Left start (falling edge, in any state other than S_IDLE, or from S_IDLE):
    - If the holding register is full: load L into the shift register, latch R into the right register, and mark holding empty.
    - If the holding register is empty: load 0 into both and pulse o_underrun for that cycle.
    - In the same cycle, drive AUD_DACDAT = MSB of the loaded L word (one-BCLK delay after the LRCK edge, I2S alignment). Set counter = 1 and go to S_LEFT.
  - S_LEFT / S_RIGHT:
    - While counter < BITLEN, shift left each cycle, drive the next bit, and increment the counter.
    - When counter == BITLEN, drive 0 and go to S_RWAIT or S_LWAIT respectively.
  - S_RWAIT: AUD_DACDAT=0. A rising edge triggers a right start: load the right register, drive its MSB, set counter = 1, go to S_RIGHT.
  - S_LWAIT: AUD_DACDAT=0. A falling edge triggers a left start.
- Early channel edge:
  - An LRCK edge arriving in S_LEFT/S_RIGHT before BITLEN bits are sent aborts the current word.
  - The block immediately performs the start for the new channel: a falling edge gives a left start, a rising edge gives a right start.
  - Remaining bits are dropped; no error flag.
- Handshake:
  - o_ready = ~holding-full.
  - Accepting a frame sets holding-full on the next edge.
  - An accept and a left-start load in the same cycle while holding is full cannot happen, because o_ready is 0 then.
  - If holding is empty at a left start and i_valid=1 in that same cycle:
    - The frame is accepted into holding.
    - The current left channel still underruns.
    - The frame is sent on the next left start.
  - i_data_* are sampled only on accept; they may change otherwise.
- Counter width: $clog2(BITLEN+1). No wrap is possible, because the counter saturates at BITLEN.
- Latency: a frame accepted at cycle t with holding previously empty begins on the first falling LRCK edge after t.
- Reset asserted mid-word: AUD_DACDAT goes to 0 immediately and the buffered frame is discarded.

Optional Feature:
DAC_HOLD_LAST_EN
- Defined: on underrun, the left/right words repeat the last transmitted frame instead of 0. The last-frame register resets to 0. o_underrun still pulses.
- Undefined: underrun sends zeros on both channels, and no last-frame register is instantiated.

Test Plan:
1. Reset, then accept L=16'hA5C3, R=16'h0F0F; toggle LRCK with a 32-BCLK half period -> DACDAT carries A5C3 MSB-first starting at the falling-edge cycle, then 0 until the rising edge; then 0F0F; o_ready rises at the left-start cycle.
2. Left start with no frame buffered -> o_underrun=1 for exactly one cycle and 16 zero bits on each channel. With DAC_HOLD_LAST_EN, the previous frame 16'hA5C3/16'h0F0F repeats instead.
3. i_valid held high with frames 1,2,3 -> only one accept per left start; o_ready low while full; frames are transmitted in order with no drop or duplicate.
4. LRCK half period of 10 BCLKs with BITLEN=16 -> each word is truncated to its 10 MSBs, the next channel starts on the edge, and no lockup occurs.
5. LRCK rising edge first after reset -> ignored (DACDAT=0); the first output bit appears at the first falling edge.
6. Assert i_rst_n=0 at bit 7 of a left word -> DACDAT=0 and o_ready=1 asynchronously; after release, the first left start underruns unless a new frame is accepted.

Source files
------------

// File: rtl/audio_dac_tx.sv
// audio_dac_tx -- I2S-style serial transmitter toward the WM8731 DAC.
//
// Accepts one stereo frame over a valid/ready handshake into a single-entry
// holding register. Each falling LRCK edge starts a left word and each rising
// edge starts a right word. Words go out MSB-first one BCLK after the edge.
//
// Ports:
//   AUD_BCLK     in   bit clock from the CODEC (only clock, rising edge)
//   i_rst_n      in   asynchronous active-low reset
//   i_data_l     in   left sample, two's complement, BITLEN bits
//   i_data_r     in   right sample, two's complement, BITLEN bits
//   i_valid      in   frame on i_data_l/i_data_r is valid
//   o_ready      out  holding register empty
//   AUD_DACLRCK  in   channel clock from the CODEC (0 = left, 1 = right)
//   AUD_DACDAT   out  registered serial data to the DAC
//   o_underrun   out  one-cycle pulse when a left word starts with no frame
//
// Build option: define DAC_HOLD_LAST_EN to repeat the last transmitted frame
// on underrun instead of sending zeros.
//
// state   | meaning
// S_IDLE  | after reset, waiting for the first falling LRCK edge
// S_LEFT  | shifting the left word
// S_RWAIT | left word done, waiting for the rising LRCK edge
// S_RIGHT | shifting the right word
// S_LWAIT | right word done, waiting for the falling LRCK edge

module audio_dac_tx #(
  parameter int BITLEN = 16
) (
  input  logic              AUD_BCLK,
  input  logic              i_rst_n,
  input  logic [BITLEN-1:0] i_data_l,
  input  logic [BITLEN-1:0] i_data_r,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              o_underrun
);

  localparam int CW = $clog2(BITLEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BITLEN);

  typedef enum logic [2:0] {
    S_IDLE, S_LEFT, S_RWAIT, S_RIGHT, S_LWAIT
  } state_t;

  state_t            state_q;
  logic              r_lrck_q;
  logic              full_q;
  logic [BITLEN-1:0] hold_l_q, hold_r_q;
  logic [BITLEN-1:0] shift_q, right_q;
  logic [CW-1:0]     cnt_q;
  logic              dacdat_q, underrun_q;

  logic              fall, rise, accept, left_start, right_start;
  logic [BITLEN-1:0] load_l, load_r;

`ifdef DAC_HOLD_LAST_EN
  logic [BITLEN-1:0] last_l_q, last_r_q;
`endif

  assign fall   = r_lrck_q & ~AUD_DACLRCK;
  assign rise   = ~r_lrck_q & AUD_DACLRCK;
  assign accept = i_valid & ~full_q;

  // A falling edge starts left from any state; a rising edge only starts right
  // once a left word has begun (also aborting a word still in flight).
  assign left_start  = fall;
  assign right_start = rise && (state_q == S_LEFT || state_q == S_RWAIT ||
                                state_q == S_RIGHT);

  always_comb begin
    load_l = hold_l_q;
    load_r = hold_r_q;
    if (!full_q) begin
`ifdef DAC_HOLD_LAST_EN
      load_l = last_l_q;
      load_r = last_r_q;
`else
      load_l = '0;
      load_r = '0;
`endif
    end
  end

  always_ff @(posedge AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      r_lrck_q   <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      shift_q    <= '0;
      right_q    <= '0;
      cnt_q      <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
`ifdef DAC_HOLD_LAST_EN
      last_l_q   <= '0;
      last_r_q   <= '0;
`endif
    end else begin
      r_lrck_q   <= AUD_DACLRCK;
      underrun_q <= 1'b0;

      // accept and a full-register left start are mutually exclusive (o_ready=0)
      if (accept) begin
        hold_l_q <= i_data_l;
        hold_r_q <= i_data_r;
        full_q   <= 1'b1;
      end else if (left_start && full_q) begin
        full_q <= 1'b0;
      end

      if (left_start) begin
        shift_q    <= load_l;
        right_q    <= load_r;
        dacdat_q   <= load_l[BITLEN-1];
        cnt_q      <= CW'(1);
        underrun_q <= ~full_q;
        state_q    <= S_LEFT;
`ifdef DAC_HOLD_LAST_EN
        if (full_q) begin
          last_l_q <= hold_l_q;
          last_r_q <= hold_r_q;
        end
`endif
      end else if (right_start) begin
        shift_q  <= right_q;
        dacdat_q <= right_q[BITLEN-1];
        cnt_q    <= CW'(1);
        state_q  <= S_RIGHT;
      end else begin
        case (state_q)
          S_LEFT, S_RIGHT: begin
            if (cnt_q < CNT_MAX) begin
              shift_q  <= shift_q << 1;
              dacdat_q <= shift_q[BITLEN-2];
              cnt_q    <= cnt_q + CW'(1);
            end else begin
              dacdat_q <= 1'b0;
              state_q  <= (state_q == S_LEFT) ? S_RWAIT : S_LWAIT;
            end
          end
          default: dacdat_q <= 1'b0;
        endcase
      end
    end
  end

  assign o_ready    = ~full_q;
  assign AUD_DACDAT = dacdat_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
module tb_audio_dac_tx;

  localparam int BITLEN = 16;

  logic              AUD_BCLK = 1'b0;
  logic              i_rst_n;
  logic [BITLEN-1:0] i_data_l, i_data_r;
  logic              i_valid;
  logic              o_ready;
  logic              AUD_DACLRCK;
  logic              AUD_DACDAT;
  logic              o_underrun;

  audio_dac_tx #(.BITLEN(BITLEN)) dut (
    .AUD_BCLK   (AUD_BCLK),
    .i_rst_n    (i_rst_n),
    .i_data_l   (i_data_l),
    .i_data_r   (i_data_r),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT (AUD_DACDAT),
    .o_underrun (o_underrun)
  );

  always #5 AUD_BCLK = ~AUD_BCLK;

  int checks = 0;
  int errors = 0;

  // one LRCK frame per record: optional push, half period, expected words
  typedef struct {
    logic        push;
    logic [15:0] l;
    logic [15:0] r;
    int          half;
    logic [15:0] el;
    logic [15:0] er;
    logic        eu;
  } vec_t;

  vec_t vecs[7];

  // auto-feed for the held-valid sequence
  logic        feed_on = 1'b0;
  int          feed_idx = 0;
  logic [15:0] feed_l[3];
  logic [15:0] feed_r[3];

  logic s_dac, s_unr, s_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive LRCK, run one BCLK, sample after the edge.
  task automatic tick(input logic lr);
    logic rb;
    AUD_DACLRCK = lr;
    rb = o_ready;
    @(posedge AUD_BCLK);
    @(negedge AUD_BCLK);
    if (feed_on && i_valid && rb) begin
      feed_idx++;
      if (feed_idx < 3) begin
        i_data_l = feed_l[feed_idx];
        i_data_r = feed_r[feed_idx];
      end else begin
        i_valid = 1'b0;
      end
    end
    s_dac = AUD_DACDAT;
    s_unr = o_underrun;
    s_rdy = o_ready;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    i_data_l = l;
    i_data_r = r;
    i_valid  = 1'b1;
    tick(AUD_DACLRCK);
    i_valid  = 1'b0;
    check("push_ready_low", s_rdy, 1'b0);
  endtask

  task automatic run_frame(input int half, input logic [15:0] el, input logic [15:0] er,
                           input logic eu, input string tag);
    logic [15:0] capl, capr;
    int nb, unr_cnt, tail_bad;
    capl = '0; capr = '0; unr_cnt = 0; tail_bad = 0;
    nb = (half < 16) ? half : 16;
    for (int i = 0; i < half; i++) begin
      tick(1'b0);
      if (i == 0) begin
        check({tag, "_underrun_at_start"}, s_unr, eu);
        check({tag, "_ready_at_start"}, s_rdy, 1'b1);
      end
      if (s_unr) unr_cnt++;
      if (i < nb) capl = {capl[14:0], s_dac};
      else if (s_dac) tail_bad++;
    end
    for (int i = 0; i < half; i++) begin
      tick(1'b1);
      if (s_unr) unr_cnt++;
      if (i < nb) capr = {capr[14:0], s_dac};
      else if (s_dac) tail_bad++;
    end
    check({tag, "_left_word"}, capl, el >> (16 - nb));
    check({tag, "_right_word"}, capr, er >> (16 - nb));
    check({tag, "_underrun_pulses"}, unr_cnt, eu ? 1 : 0);
    check({tag, "_tail_zero"}, tail_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] u1_l, u1_r, u5_l, u5_r, u3_l, u3_r;
`ifdef DAC_HOLD_LAST_EN
    u1_l = 16'hA5C3; u1_r = 16'h0F0F;
    u5_l = 16'hC3C3; u5_r = 16'h3C3C;
    u3_l = 16'h5555; u3_r = 16'h6666;
`else
    u1_l = 16'h0000; u1_r = 16'h0000;
    u5_l = 16'h0000; u5_r = 16'h0000;
    u3_l = 16'h0000; u3_r = 16'h0000;
`endif
    vecs[0] = '{1'b1, 16'hA5C3, 16'h0F0F, 32, 16'hA5C3, 16'h0F0F, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 32, u1_l,     u1_r,     1'b1};
    vecs[2] = '{1'b1, 16'h1234, 16'hFEDC, 32, 16'h1234, 16'hFEDC, 1'b0};
    vecs[3] = '{1'b1, 16'h8001, 16'h7FFE, 10, 16'h8001, 16'h7FFE, 1'b0};
    vecs[4] = '{1'b1, 16'hC3C3, 16'h3C3C, 10, 16'hC3C3, 16'h3C3C, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 10, u5_l,     u5_r,     1'b1};
    vecs[6] = '{1'b1, 16'h5A5A, 16'hA5A5, 32, 16'h5A5A, 16'hA5A5, 1'b0};

    i_rst_n = 1'b0; i_valid = 1'b0; i_data_l = '0; i_data_r = '0; AUD_DACLRCK = 1'b0;
    repeat (2) @(negedge AUD_BCLK);
    check("reset_dacdat", AUD_DACDAT, 1'b0);
    check("reset_underrun", o_underrun, 1'b0);
    check("reset_ready", o_ready, 1'b1);
    i_rst_n = 1'b1;

    // rising edge first after reset is ignored
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      check("rise_first_ignored", s_dac, 1'b0);
    end

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].push) push(vecs[v].l, vecs[v].r);
      run_frame(vecs[v].half, vecs[v].el, vecs[v].er, vecs[v].eu, $sformatf("vec%0d", v));
    end

    // i_valid held high across three frames
    feed_l = '{16'h1111, 16'h3333, 16'h5555};
    feed_r = '{16'h2222, 16'h4444, 16'h6666};
    feed_idx = 0;
    feed_on  = 1'b1;
    i_data_l = feed_l[0];
    i_data_r = feed_r[0];
    i_valid  = 1'b1;
    tick(1'b1);
    check("held_first_accept_ready", s_rdy, 1'b0);
    tick(1'b1);
    tick(1'b1);
    check("held_single_accept", feed_idx, 1);
    for (int k = 0; k < 3; k++) begin
      run_frame(32, feed_l[k], feed_r[k], 1'b0, $sformatf("held%0d", k));
      check($sformatf("held%0d_accepts", k), feed_idx, (k + 2 < 3) ? k + 2 : 3);
      check($sformatf("held%0d_ready_end", k), s_rdy, (k < 2) ? 1'b0 : 1'b1);
    end
    feed_on = 1'b0;
    run_frame(32, u3_l, u3_r, 1'b1, "held_drain");

    // reset in the middle of a left word, with a second frame buffered
    push(16'h9999, 16'h6666);
    for (int i = 0; i < 5; i++) tick(1'b0);
    push(16'hBEEF, 16'hCAFE);
    tick(1'b0);
    tick(1'b0);
    check("midword_bit8", s_dac, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_reset_dacdat", AUD_DACDAT, 1'b0);
    check("async_reset_ready", o_ready, 1'b1);
    @(posedge AUD_BCLK);
    @(negedge AUD_BCLK);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1);
    run_frame(32, 16'h0000, 16'h0000, 1'b1, "post_reset");
    push(16'h0F0F, 16'hF00F);
    run_frame(32, 16'h0F0F, 16'hF00F, 1'b0, "post_reset_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
